// File: rtl/fmaunpack.sv
// fmaunpack: unpacks an IEEE-754 operand into sign/extended exponent/explicit mantissa, normalising subnormals one bit per cycle.
module fmaunpack #(
  parameter int NE = 5,
  parameter int NF = 10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [NE+NF:0]  in_x,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_sign,
  output logic [NE+1:0]   out_exp,
  output logic [NF:0]     out_mant,
  output logic            out_zero,
  output logic            out_subn,
  output logic            out_inf,
  output logic            out_nan,
  output logic            out_snan
);
  typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;
  state_t state, state_nx;
  logic [NE-1:0] e;
  logic [NF-1:0] f;
  logic e_zero, e_max, f_nz, accept;
  assign e = in_x[NE+NF-1:NF];
  assign f = in_x[NF-1:0];
  assign e_zero = ~|e;
  assign e_max = &e;
  assign f_nz = |f;
  assign accept = in_valid & in_ready & ~flush;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  // in NORM the shift lands the leading one when the current bit below the top is set
  always_comb
    state_nx = flush ? IDLE :
               state == IDLE ? (in_valid ? ((e_zero & f_nz) ? NORM : DONE) : IDLE) :
               state == NORM ? (out_mant[NF-1] ? DONE : NORM) :
               (out_ready ? IDLE : DONE);
  always_comb begin
    in_ready = state == IDLE;
    out_valid = state == DONE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      out_sign <= 1'b0;
      out_exp <= '0;
      out_mant <= '0;
      out_zero <= 1'b0;
      out_subn <= 1'b0;
      out_inf <= 1'b0;
      out_nan <= 1'b0;
      out_snan <= 1'b0;
    end else if (accept) begin
      out_sign <= in_x[NE+NF];
      out_exp <= e_zero ? {{(NE+1){1'b0}}, f_nz} : {2'b00, e};
      out_mant <= {~e_zero, f};
      out_zero <= e_zero & ~f_nz;
      out_subn <= e_zero & f_nz;
      out_inf <= e_max & ~f_nz;
      out_nan <= e_max & f_nz;
      out_snan <= e_max & f_nz & ~f[NF-1];
    end else if (state == NORM && !flush) begin
      out_mant <= out_mant << 1;
      out_exp <= out_exp - (NE+2)'(1);
    end
endmodule

// File: tb/tb_fmaunpack.sv
// tb_fmaunpack: directed and random operands checked against a arithmetic model of binary16 unpacking.
module tb_fmaunpack;
  logic clk = 0, reset = 1, flush = 0, in_valid = 0, out_ready = 0;
  logic [15:0] in_x = '0;
  logic in_ready, out_valid, out_sign, out_zero, out_subn, out_inf, out_nan, out_snan;
  logic [6:0] out_exp;
  logic [10:0] out_mant;
  int checks = 0, passes = 0, fails = 0;

  fmaunpack #(.NE(5), .NF(10)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .out_valid(out_valid), .out_ready(out_ready), .out_sign(out_sign),
    .out_exp(out_exp), .out_mant(out_mant), .out_zero(out_zero), .out_subn(out_subn),
    .out_inf(out_inf), .out_nan(out_nan), .out_snan(out_snan)
  );

  always #5 clk = ~clk;

  function automatic int lz10(input int f);
    int n = 0;
    while (n < 10 && ((f << n) & 512) == 0) n++;
    return n;
  endfunction

  // {sign, exp[6:0], mant[10:0], zero, subn, inf, nan, snan}
  function automatic logic [23:0] model(input logic [15:0] x);
    int e = int'(x[14:10]);
    int f = int'(x[9:0]);
    int ex, m;
    logic z = 0, sb = 0, inf = 0, nan = 0, sn = 0;
    if (e == 0 && f == 0) begin ex = 0; m = 0; z = 1; end
    else if (e == 0) begin ex = -lz10(f); m = f << (lz10(f) + 1); sb = 1; end
    else begin
      ex = e; m = 1024 + f;
      inf = (e == 31) && f == 0;
      nan = (e == 31) && f != 0;
      sn = nan && f < 512;
    end
    return {x[15], 7'(ex), 11'(m), z, sb, inf, nan, sn};
  endfunction

  function automatic int latency(input logic [15:0] x);
    return (x[14:10] == 0 && x[9:0] != 0) ? lz10(int'(x[9:0])) + 2 : 1;
  endfunction

  function automatic logic [23:0] dut_vec();
    return {out_sign, out_exp, out_mant, out_zero, out_subn, out_inf, out_nan, out_snan};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    check("idle_wait", {31'd0, in_ready}, 1);
  endtask

  task automatic run_op(input logic [15:0] x, input int hold);
    int n = 1;
    logic [23:0] expv = model(x);
    wait_idle();
    in_valid = 1; in_x = x; out_ready = 0;
    @(negedge clk);
    in_valid = 0;
    while (!out_valid && n < 40) begin @(negedge clk); n++; end
    check("latency", n, latency(x));
    check("result", {8'd0, dut_vec()}, {8'd0, expv});
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom); in_x = 16'($urandom);
      @(negedge clk);
      check("hold_result", {8'd0, dut_vec()}, {8'd0, expv});
      check("hold_busy", {30'd0, in_ready, out_valid}, 1);
    end
    in_valid = 0; out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    check("release", {30'd0, in_ready, out_valid}, 2);
  endtask

  initial begin
    #1;
    check("reset_outputs", {8'd0, dut_vec()}, 0);
    check("reset_hs", {30'd0, in_ready, out_valid}, 2);
    @(negedge clk); reset = 0;
    run_op(16'h3C00, 0);
    check("one_exp", {25'd0, out_exp}, 7'h0F);
    run_op(16'h0001, 1);
    check("min_subn_exp", {25'd0, out_exp}, 7'h77);
    check("min_subn_mant", {21'd0, out_mant}, 11'h400);
    run_op(16'h0200, 0);
    run_op(16'h7C00, 0);
    run_op(16'h7D00, 0);
    check("snan", {30'd0, out_nan, out_snan}, 3);
    run_op(16'h7E00, 0);
    check("qnan", {30'd0, out_nan, out_snan}, 2);
    run_op(16'h8000, 0);
    run_op(16'h4248, 5);
    check("bp_mant", {21'd0, out_mant}, 11'h648);
    // abort mid-normalisation with flush
    in_valid = 1; in_x = 16'h0001;
    @(negedge clk); in_valid = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("flush_no_valid", {31'd0, out_valid}, 0);
    end
    flush = 1;
    @(negedge clk); flush = 0;
    check("flush_idle", {30'd0, in_ready, out_valid}, 2);
    run_op(16'h3C00, 0);
    // async reset mid-normalisation
    in_valid = 1; in_x = 16'h8001;
    @(negedge clk); in_valid = 0;
    @(negedge clk); @(negedge clk);
    reset = 1; #1;
    check("areset_outputs", {8'd0, dut_vec()}, 0);
    check("areset_hs", {30'd0, in_ready, out_valid}, 2);
    @(negedge clk); reset = 0;
    run_op(16'hBC00, 0);
    // flush blocks accept in IDLE
    flush = 1; in_valid = 1; in_x = 16'h4000;
    @(negedge clk); flush = 0; in_valid = 0;
    check("flush_vs_accept", {30'd0, in_ready, out_valid}, 2);
    @(negedge clk);
    check("flush_vs_accept2", {30'd0, in_ready, out_valid}, 2);
    // flush together with output handshake
    in_valid = 1; in_x = 16'h3C00;
    @(negedge clk); in_valid = 0;
    check("pre_flush_done", {31'd0, out_valid}, 1);
    flush = 1; out_ready = 1;
    @(negedge clk); flush = 0; out_ready = 0;
    check("flush_done", {30'd0, in_ready, out_valid}, 2);
    @(negedge clk);
    check("flush_done_nodup", {30'd0, in_ready, out_valid}, 2);
    for (int i = 0; i < 40; i++) begin
      logic [15:0] x = 16'($urandom);
      if ($urandom_range(0, 2) == 0) x[14:10] = 5'd0;
      run_op(x, $urandom_range(0, 3));
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/fmaunpack.md
# fmaunpack

Multi-cycle operand unpacker for the fma16 datapath. It is the input-side counterpart to the result rounder/packer. It accepts one packed IEEE-754 binary operand per handshake and splits it into sign, extended biased exponent and mantissa with the explicit leading bit. Subnormals are normalised by an iterative one-bit-per-cycle left shift, and the operand is classified. Results go to the multiplier/aligner through a valid/ready output handshake.

## Interface
- NE, 5, exponent field width
- NF, 10, fraction field width (defaults give binary16)
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- flush  in  1  synchronous abort; returns the block to IDLE
- in_valid  in  1  operand valid
- in_ready  out  1  block can accept an operand
- in_x  in  NE+NF+1  packed operand {sign, exp, fract}
- out_valid  out  1  unpacked result valid
- out_ready  in  1  consumer accepts the result
- out_sign  out  1  operand sign
- out_exp  out  NE+2  biased exponent, two's complement, may be ≤0 after normalisation
- out_mant  out  NF+1  mantissa {leading bit, fraction}
- out_zero, out_subn, out_inf, out_nan, out_snan  out  1 each  classification flags

## Operation
- States: IDLE, NORM, DONE. `in_ready = (state==IDLE)`. `out_valid = (state==DONE)`.
- Accept when `in_valid & in_ready`. Decode {s,e,f} from in_x into registers on the same edge.
  - e==0, f==0: exp=0, mant=0, zero=1. Go to DONE.
  - e==0, f!=0: exp=1, mant={0,f}, subn=1. Go to NORM.
  - e==all-ones, f==0: exp=e, mant={1,f}, inf=1. Go to DONE.
  - e==all-ones, f!=0: exp=e, mant={1,f}, nan=1, snan=~f[NF-1]. Go to DONE.
  - Otherwise: exp=e (zero-extended), mant={1,f}. Go to DONE.
- NORM: each edge does mant<<=1 and exp-=1 (NE+2-bit wrap arithmetic). Go to DONE when the shifted mant[NF]==1.
  - Shift count is lz(f)+1, where lz counts leading zeros over NF bits. Range is 1..NF.
  - Final exp is 1-(lz(f)+1), so the minimum is 1-NF.
- DONE: outputs held stable until `out_ready`. On the handshake edge, go to IDLE. Flags and data are not cleared on handshake.
- Sign passes through unchanged for every class, including zero and NaN.
- flush: on the next edge, state goes to IDLE from any state. Data registers keep their values, and out_valid drops. flush has priority over accept and output handshake in the same cycle. An operand offered while flush is high is not accepted.
- in_valid while not in IDLE: ignored, with no side effects.

## Timing
- Reset (asynchronous, immediate): state=IDLE, so in_ready=1 and out_valid=0. out_sign, out_exp, out_mant and all flags go to 0.
- Reset asserted mid-NORM or in DONE: the result is discarded. The first edge after deassertion can accept.
- Latency counts edges from the accept edge to out_valid high.
  - Non-subnormal: 1 edge.
  - Subnormal: 1+lz(f)+1 edges (binary16 range 2..11).
- Throughput is one operand per (latency+1) cycles minimum. The IDLE cycle after the output handshake is mandatory, so there is no back-to-back overlap.
- Outputs are registered only. No combinational path from in_x to any output, or from out_ready to in_ready.

## Test plan
- 1.0, in_x=0x3C00 → out_valid 1 edge after accept. sign=0, exp=0x0F, mant=0x400, all flags 0.
- Smallest subnormal, 0x0001 → 10 NORM cycles, out_valid 11 edges after accept. exp=0x77 (−9), mant=0x400, subn=1. Also 0x0200 → 1 shift, exp=0x00, mant=0x400, out_valid 2 edges after accept.
- Specials:
  - 0x7C00 → inf=1, exp=0x1F, mant=0x400.
  - 0x7D00 → nan=1, snan=1.
  - 0x7E00 → nan=1, snan=0.
  - 0x8000 → sign=1, zero=1, exp=0, mant=0.
- Backpressure: accept 0x4248, hold out_ready=0 for 5 cycles while toggling in_valid with other operands → outputs stable (exp=0x10, mant=0x648), in_ready=0, and the later operands are not consumed. Raise out_ready → IDLE on the next edge, in_ready=1.
- Abort: accept 0x0001, assert flush on the 3rd NORM cycle → IDLE on the next edge with out_valid never asserted. Then accept 0x3C00 and check the correct result. Repeat with async reset pulsed mid-NORM → all outputs 0 immediately.
- Simultaneous events: flush together with in_valid in IDLE → not accepted. flush together with out_ready in DONE → IDLE, a single drop, no duplicate output.
